// File: rtl/imem_dmem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Reads are tracked in an in-order tag FIFO so each return is routed to its owner.
module imem_dmem_port_arbiter #(
  parameter  int AW              = 16,
  parameter  int DW              = 16,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int STARVE_LIMIT    = 3,
  localparam int CW              = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_flush,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_byteen,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] m_addr,
  output logic          m_rd,
  output logic          m_wr,
  output logic [DW-1:0] m_wdata,
  output logic [1:0]    m_byteen,
  input  logic          m_waitreq,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic [CW-1:0] outstanding,
  output logic          err_unexp_rvalid
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic fetch;
    logic drop;
  } tag_t;

  tag_t [MAX_OUTSTANDING-1:0] tag_q;
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] starve_q;
  logic          err_q;

  logic full, empty, f_cand, f_elig, d_elig, f_win, d_win, push, pop;
  tag_t head;

  assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);

  // Writes bypass the full check: they never occupy a tag slot.
  assign f_cand = f_req & ~f_flush;
  assign f_elig = reset_n & f_cand & ~full;
  assign d_elig = reset_n & (d_wr | (d_rd & ~full));
  assign f_win  = f_elig & (~d_elig | (starve_q == SW'(STARVE_LIMIT)));
  assign d_win  = d_elig & ~f_win;
  assign f_gnt  = f_win & ~m_waitreq;
  assign d_gnt  = d_win & ~m_waitreq;

  always_comb begin
    m_addr   = '0;
    m_rd     = 1'b0;
    m_wr     = 1'b0;
    m_wdata  = '0;
    m_byteen = '0;
    if (f_win) begin
      m_addr   = f_addr & ~AW'(1);
      m_rd     = 1'b1;
      m_byteen = 2'b11;
    end else if (d_win) begin
      m_addr   = d_addr;
      m_rd     = d_rd;
      m_wr     = d_wr;
      m_wdata  = d_wdata;
      m_byteen = d_byteen;
    end
  end

  assign push = f_gnt | (d_gnt & d_rd);
  assign pop  = m_rvalid & ~empty;
  assign head = tag_q[rp_q];

  // A flush in the pop cycle must also kill the head's return.
  assign f_rvalid = pop & head.fetch & ~head.drop & ~f_flush;
  assign d_rvalid = pop & ~head.fetch;
  assign f_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  assign outstanding      = cnt_q;
  assign err_unexp_rvalid = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        if (f_flush && tag_q[i].fetch) tag_q[i].drop <= 1'b1;
      if (push) begin
        tag_q[wp_q] <= tag_t'{fetch: f_gnt, drop: 1'b0};
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (m_rvalid && empty) err_q <= 1'b1;
      // Only losing arbitration to data counts; a full FIFO or a stall of fetch's own command holds.
      if (f_elig && d_win)
        starve_q <= (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
      else if (f_gnt || !f_cand)
        starve_q <= '0;
    end
  end
endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed scenarios then random traffic, checked against a queue-based model of the arbiter.
module tb_imem_dmem_port_arbiter;
  localparam int AW = 16, DW = 16, MAXO = 4, LIM = 3, CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          f_req, f_flush, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          d_rd, d_wr, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [1:0]    d_byteen;
  logic [AW-1:0] m_addr;
  logic          m_rd, m_wr, m_waitreq, m_rvalid;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    m_byteen;
  logic [CW-1:0] outstanding;
  logic          err_unexp_rvalid;

  imem_dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata), .m_byteen(m_byteen),
    .m_waitreq(m_waitreq), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .outstanding(outstanding), .err_unexp_rvalid(err_unexp_rvalid)
  );

  typedef struct { bit fetch; bit drop; } ent_t;
  ent_t tq[$];
  int   starve;
  bit   err_m;
  int   n_assert = 0, n_fail = 0;

  int            winner;  // 0 none, 1 fetch, 2 data
  bit            e_fok, e_fg, e_dg, e_mrd, e_mwr, e_frv, e_drv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [1:0]    e_be;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic eval();
    bit full, d_ok;
    winner = 0; e_fok = 0; e_fg = 0; e_dg = 0; e_mrd = 0; e_mwr = 0;
    e_frv = 0; e_drv = 0; e_addr = '0; e_wdata = '0; e_be = '0;
    if (reset_n) begin
      full  = (tq.size() == MAXO);
      d_ok  = d_wr || (d_rd && !full);
      e_fok = f_req && !f_flush && !full;
      if (e_fok && (!d_ok || starve == LIM)) winner = 1;
      else if (d_ok) winner = 2;
      e_fg = (winner == 1) && !m_waitreq;
      e_dg = (winner == 2) && !m_waitreq;
      if (winner == 1) begin
        e_addr = {f_addr[AW-1:1], 1'b0}; e_mrd = 1; e_be = 2'b11;
      end else if (winner == 2) begin
        e_addr = d_addr; e_mrd = d_rd; e_mwr = d_wr; e_wdata = d_wdata; e_be = d_byteen;
      end
      if (m_rvalid && tq.size() > 0) begin
        e_frv = tq[0].fetch && !tq[0].drop && !f_flush;
        e_drv = !tq[0].fetch;
      end
    end
  endtask

  task automatic update();
    ent_t e;
    bit f_cand;
    if (!reset_n) return;
    f_cand = f_req && !f_flush;
    if (e_fok && winner == 2) starve = (starve < LIM) ? starve + 1 : LIM;
    else if (e_fg || !f_cand) starve = 0;
    if (f_flush) foreach (tq[i]) if (tq[i].fetch) tq[i].drop = 1;
    if (m_rvalid) begin
      if (tq.size() > 0) void'(tq.pop_front());
      else err_m = 1;
    end
    if (e_fg || (e_dg && d_rd)) begin
      e.fetch = e_fg; e.drop = 0;
      tq.push_back(e);
    end
  endtask

  task automatic settle(string t);
    #1;
    eval();
    chk({t, ":f_gnt"}, f_gnt, e_fg);
    chk({t, ":d_gnt"}, d_gnt, e_dg);
    chk({t, ":m_rd"}, m_rd, e_mrd);
    chk({t, ":m_wr"}, m_wr, e_mwr);
    chk({t, ":m_addr"}, m_addr, e_addr);
    chk({t, ":m_wdata"}, m_wdata, e_wdata);
    chk({t, ":m_byteen"}, m_byteen, e_be);
    chk({t, ":f_rvalid"}, f_rvalid, e_frv);
    chk({t, ":d_rvalid"}, d_rvalid, e_drv);
    chk({t, ":outstanding"}, outstanding, tq.size());
    chk({t, ":err"}, err_unexp_rvalid, err_m);
    if (e_frv) chk({t, ":f_rdata"}, f_rdata, m_rdata);
    if (e_drv) chk({t, ":d_rdata"}, d_rdata, m_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    f_req = 0; f_flush = 0; f_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0;
    d_wdata = '0; d_byteen = '0; m_waitreq = 0; m_rvalid = 0;
  endtask

  task automatic drain(string t);
    idle_inputs();
    for (int k = 0; k < MAXO && tq.size() > 0; k++) begin
      m_rvalid = 1; m_rdata = DW'($urandom);
      settle(t); tick();
    end
    m_rvalid = 0;
  endtask

  task automatic apply_reset();
    reset_n = 0; tq.delete(); starve = 0; err_m = 0;
  endtask

  initial begin
    idle_inputs();
    m_rdata = '0;
    apply_reset();
    @(negedge clk);
    // reset: active requests must not leak onto the port
    f_req = 1; d_rd = 1; f_addr = 16'h0010; d_addr = 16'h0020;
    settle("rst"); tick();
    reset_n = 1; idle_inputs();
    settle("idle"); tick();

    // 1: continuous contention, 1-cycle memory
    f_req = 1; d_rd = 1; f_addr = 16'h0040; d_addr = 16'h0100;
    for (int i = 0; i < 12; i++) begin
      m_rvalid = (tq.size() > 0); m_rdata = DW'($urandom);
      settle("t1");
      chk("t1_pattern_f", f_gnt, (i % 4) == 3);
      if (i > 0) chk("t1_route_d", d_rvalid, ((i - 1) % 4) != 3);
      tick();
    end
    drain("t1d");

    // 2: fill FIFO with fetches; write still goes through when full
    for (int i = 0; i < 4; i++) begin
      f_req = 1; f_addr = AW'(16'h0200 + 2 * i);
      settle("t2"); tick();
    end
    d_wr = 1; d_addr = 16'h0300; d_wdata = 16'hBEEF; d_byteen = 2'b01;
    settle("t2full");
    chk("t2_outstanding", outstanding, 4);
    chk("t2_f_gnt", f_gnt, 0);
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_m_wr", m_wr, 1);
    tick();
    drain("t2d");

    // 3: flush kills in-flight fetch returns
    for (int i = 0; i < 3; i++) begin
      f_req = 1; f_addr = AW'(16'h0400 + 2 * i);
      settle("t3"); tick();
    end
    f_req = 0; f_flush = 1;
    settle("t3flush"); tick();
    f_flush = 0;
    for (int i = 0; i < 3; i++) begin
      m_rvalid = 1; m_rdata = DW'(16'h1111 * (i + 1));
      settle("t3ret");
      chk("t3_f_rvalid", f_rvalid, 0);
      tick();
    end
    m_rvalid = 0;
    settle("t3end");
    chk("t3_outstanding", outstanding, 0);
    tick();

    // 4: memory stall holds the data read command
    d_rd = 1; d_addr = 16'h0ABC; m_waitreq = 1;
    for (int i = 0; i < 5; i++) begin
      settle("t4stall");
      chk("t4_m_rd", m_rd, 1);
      chk("t4_m_addr", m_addr, 16'h0ABC);
      chk("t4_d_gnt", d_gnt, 0);
      tick();
    end
    m_waitreq = 0;
    settle("t4go");
    chk("t4_d_gnt_rise", d_gnt, 1);
    tick();
    drain("t4d");

    // 5: fetch address alignment
    f_req = 1; f_addr = 16'h0013;
    settle("t5");
    chk("t5_m_addr", m_addr, 16'h0012);
    chk("t5_m_byteen", m_byteen, 2'b11);
    tick();
    drain("t5d");

    // 6: reset with reads in flight, then a stray return
    f_req = 1; d_rd = 1; d_addr = 16'h0500; f_addr = 16'h0600;
    for (int i = 0; i < 2; i++) begin
      settle("t6"); tick();
    end
    apply_reset();
    settle("t6rst");
    chk("t6_m_rd", m_rd, 0);
    chk("t6_outstanding", outstanding, 0);
    tick();
    reset_n = 1; idle_inputs();
    m_rvalid = 1; m_rdata = 16'h5A5A;
    settle("t6stray");
    chk("t6_f_rvalid", f_rvalid, 0);
    chk("t6_d_rvalid", d_rvalid, 0);
    tick();
    m_rvalid = 0;
    settle("t6err");
    chk("t6_err", err_unexp_rvalid, 1);
    tick();

    // random traffic
    apply_reset();
    settle("rrst"); tick();
    reset_n = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      f_req     = ($urandom % 4) != 0;
      f_flush   = ($urandom % 10) == 0;
      r         = $urandom % 4;
      d_rd      = (r == 1);
      d_wr      = (r == 2);
      f_addr    = AW'($urandom);
      d_addr    = AW'($urandom);
      d_wdata   = DW'($urandom);
      d_byteen  = 2'($urandom);
      m_waitreq = ($urandom % 4) == 0;
      m_rvalid  = (tq.size() > 0) && ($urandom % 2 == 1);
      m_rdata   = DW'($urandom);
      settle("rnd"); tick();
    end
    drain("rndd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares the CPU's single 16-bit memory port between two requesters: instruction fetch and the load/store (data) stage.
- Selects one requester per cycle and drives the shared port.
- Tracks outstanding reads in an in-order tag FIFO and routes each returned read word to its owner.
- Drops in-flight fetch returns when the pipeline flushes on a taken branch.
- Sits between the fetch/memory stages and the external memory interface.

Parameters:
- AW, 16, address width in bits.
- DW, 16, data width in bits.
- MAX_OUTSTANDING, 4, tag FIFO depth = maximum reads in flight; power of two, at least 2.
- STARVE_LIMIT, 3, consecutive cycles fetch may lose to data before fetch is forced to win; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  AW  fetch address; bit 0 is ignored.
- f_flush  in  1  branch taken: discard all outstanding fetch reads.
- f_gnt  out  1  fetch request accepted by memory this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DW  fetch read data.
- d_rd  in  1  data read request.
- d_wr  in  1  data write request; d_rd and d_wr are never both high.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_byteen  in  2  write byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid.
- d_rdata  out  DW  data read data.
- m_addr  out  AW  memory address.
- m_rd  out  1  memory read strobe.
- m_wr  out  1  memory write strobe.
- m_wdata  out  DW  memory write data.
- m_byteen  out  2  memory byte enables.
- m_waitreq  in  1  memory stall; a command is accepted only when this is low.
- m_rvalid  in  1  memory read data valid; returns arrive in issue order.
- m_rdata  in  DW  memory read data.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_unexp_rvalid  out  1  sticky: m_rvalid was seen while the FIFO was empty.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FIFO emptied, starvation counter = 0, err_unexp_rvalid = 0.
  - Every output is 0, except f_rdata/d_rdata, which follow m_rdata combinationally.
  - Reads in flight at reset are lost; their late returns set err_unexp_rvalid (by design).
- Arbitration (combinational, same cycle):
  - Candidates: data if (d_rd or d_wr); fetch if (f_req and not f_flush).
  - A read candidate is ineligible while the FIFO is full. Writes stay eligible when the FIFO is full.
  - Winner selection:
    - Only one eligible candidate: it wins.
    - Both eligible: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - Winner drives m_addr / m_rd / m_wr / m_wdata / m_byteen.
    - Fetch drives m_addr = {f_addr[AW-1:1], 0}, m_byteen = 2'b11, m_wdata = 0.
    - No winner: m_rd = m_wr = 0, m_addr = 0.
  - Grant: x_gnt = (x is winner) & ~m_waitreq. The command is held (repeated) while m_waitreq is high. Grant is a combinational function of m_waitreq.
- Starvation counter:
  - On the clock edge: if fetch is a candidate and not granted because data won, increment (saturate at STARVE_LIMIT).
  - Cleared on f_gnt, or when fetch is not a candidate.
  - Stalls caused by m_waitreq alone do not change the counter.
- Tag FIFO (entry = owner bit + discard bit):
  - Push on every granted read. Pop on every m_rvalid. Push and pop in the same cycle leave occupancy unchanged.
  - m_rvalid pops the head entry:
    - owner = fetch, discard = 0: f_rvalid = 1 with m_rdata.
    - owner = data: d_rvalid = 1.
    - discard = 1: no valid output is asserted.
  - f_flush sets discard on every fetch entry currently in the FIFO. This includes the entry being popped that same cycle, so flush suppresses a same-cycle f_rvalid.
  - Fetch is not a candidate in the flush cycle, so no new fetch entry is pushed that cycle.
  - Data entries are never discarded.
  - m_rvalid with the FIFO empty: no pop, no valid output, err_unexp_rvalid set to 1 until reset.
- Latency:
  - Grant is 0 cycles from request when memory is not stalled.
  - Read data is returned in the same cycle as m_rvalid (no extra register stage).

Test Plan:
1. f_req and d_rd held high continuously, m_waitreq = 0, memory 1-cycle latency -> grants go data ×3, fetch ×1, repeating with STARVE_LIMIT = 3; each return is routed to the owner of that issue, in order.
2. Four fetch reads issued with m_rvalid withheld -> outstanding = 4 and f_gnt = 0 on the 5th request, while a d_wr in that cycle gets d_gnt = 1 and m_wr = 1.
3. Three fetch reads outstanding, f_flush pulsed, then data return values 0x1111, 0x2222, 0x3333 -> f_rvalid stays 0 for all three and outstanding returns to 0.
4. d_rd held with m_waitreq high for 5 cycles -> m_rd/m_addr stable, d_gnt = 0 throughout and rises in the cycle m_waitreq falls; starve counter unchanged.
5. f_addr = 0x0013 granted -> m_addr = 0x0012, m_byteen = 2'b11.
6. reset_n asserted low mid-stream with 2 reads outstanding, then a stray m_rvalid arrives -> outputs are 0 immediately, err_unexp_rvalid = 1, and f_rvalid/d_rvalid stay 0.
